sync_fifo_out: RTL and testbench
================================

# sync_fifo_out

Read-side stage of the single-clock FIFO. It sits directly downstream of the FIFO write/storage stage: it compares its own read pointer against the write pointer exported by that stage, reads the stage's combinational storage port, and presents entries to the consumer through a registered valid/ready output. It owns the read pointer that the write stage uses for its full detection.

## Interface
- DATA_WIDTH, 16, entry width in bits
- ADDR_WIDTH, 4, storage address width; depth = 2^ADDR_WIDTH; legal range ≥ 1
- clk_i  input  1  clock, all state on rising edge
- resetn_i  input  1  asynchronous, active-low reset
- write_addr_i  input  ADDR_WIDTH+1  write pointer from the write stage, MSB is the wrap bit
- read_data_i  input  DATA_WIDTH  storage word at read_addr_o, combinational from the write stage
- read_addr_o  output  ADDR_WIDTH+1  read pointer, MSB is the wrap bit, driven from a register
- fifo_read_valid_h_o  output  1  fifo_read_data_o holds a valid entry
- fifo_read_ready_h_i  input  1  consumer accepts the entry this cycle
- fifo_read_data_o  output  DATA_WIDTH  output register
- fifo_empty_h_o  output  1  equals ~fifo_read_valid_h_o
- fifo_level_o  output  ADDR_WIDTH+1  entries held: storage plus output register (see Configuration)

## Operation
- Storage empty: mem_empty = (read_addr_o == write_addr_i), all ADDR_WIDTH+1 bits compared.
- Pop: pop = fifo_read_valid_h_o & fifo_read_ready_h_i.
- Load: load = ~mem_empty & (~fifo_read_valid_h_o | pop).
- On load: fifo_read_data_o <= read_data_i; read_addr_o <= read_addr_o + 1, modulo 2^(ADDR_WIDTH+1) so the wrap bit toggles every depth entries; fifo_read_valid_h_o <= 1.
- On pop without load: fifo_read_valid_h_o <= 0; data register holds its value.
- Neither: all state holds.
- Output state: EMPTY (valid=0), VALID (valid=1). EMPTY→VALID on load. VALID→EMPTY on pop & mem_empty. VALID→VALID on pop & load (back-to-back) or on stall (ready=0).
- Stall: while valid=1 and ready=0, fifo_read_data_o and read_addr_o are stable.
- Ready is ignored while valid=0. No entry is dropped or duplicated.
- Full detection belongs to the write stage. This block never advances read_addr_o past write_addr_i.

## Timing
- Reset values: read_addr_o=0, fifo_read_valid_h_o=0, fifo_read_data_o=0, fifo_empty_h_o=1, fifo_level_o=0.
- Reset is asynchronous and applies mid-transfer. Any held entry is discarded. The write stage shares resetn_i, so both pointers return to 0 together.
- Latency: a write accepted at rising edge k raises write_addr_i after edge k. With the block EMPTY, fifo_read_valid_h_o is high after edge k+1.
- Throughput: one entry per cycle sustained while ready=1 and storage is non-empty.
- A storage slot is freed the edge after its load, because read_addr_o advances then. Depth plus the output register holds 2^ADDR_WIDTH + 1 entries.
- All outputs are registered or derived from registers, except fifo_empty_h_o (inverter) and fifo_level_o (see below). There is no combinational path from fifo_read_ready_h_i to any output.

## Configuration
- SYNC_FIFO_OUT_LEVEL_EN defined:
  - fifo_level_o = ((write_addr_i - read_addr_o) mod 2^(ADDR_WIDTH+1)) + fifo_read_valid_h_o, combinational from write_addr_i and registers.
  - Range 0..2^ADDR_WIDTH+1.
- SYNC_FIFO_OUT_LEVEL_EN undefined:
  - fifo_level_o is tied to 0 and no subtractor is built.
  - All other behaviour is identical.

## Test plan
- Reset, then write 0x1234 at edge 3 with ready=0 → valid=1 and data=0x1234 after edge 4; read_addr_o=1; level=1; data held for 10 stalled cycles.
- Write 0x0001..0x0010 back-to-back (ADDR_WIDTH=4) with ready=1 throughout → 16 consecutive valid cycles in order; read_addr_o=0x10 (wrap bit set); then empty=1.
- Fill storage with 16 entries while ready=0:
  - Write stage reports full after 17 writes (output register holds entry 1); level=17 with macro.
  - Then ready=1 → entries 1..17 appear in order and the write stage's full drops the edge after the first pop.
- 40 entries with random ready and random writes across two pointer wraps → output sequence equals input sequence; no duplicates or losses.
- Assert resetn_i low asynchronously while valid=1 and 5 entries are stored → outputs go to reset values immediately; after release, no stale entry appears.
- Build without SYNC_FIFO_OUT_LEVEL_EN, repeat the fill scenario → fifo_level_o=0 always; data and handshake identical to the macro-enabled build.

Source files
------------

// File: rtl/sync_fifo_out.sv
// sync_fifo_out: read-side stage of the single-clock FIFO.
// Compares its read pointer against the write stage's pointer, pulls words from
// the write stage's combinational storage port and presents them through a
// registered valid/ready output register.
// Optional feature macro: SYNC_FIFO_OUT_LEVEL_EN (adds the fifo_level_o occupancy count).
module sync_fifo_out #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic [ADDR_WIDTH:0]   write_addr_i,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  output logic [ADDR_WIDTH:0]   read_addr_o,
  output logic                  fifo_read_valid_h_o,
  input  logic                  fifo_read_ready_h_i,
  output logic [DATA_WIDTH-1:0] fifo_read_data_o,
  output logic                  fifo_empty_h_o,
  output logic [ADDR_WIDTH:0]   fifo_level_o
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_VALID = 1'b1
  } state_e;

  state_e                  state_q;
  state_e                  state_d;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    mem_empty_c;
  logic                    pop_c;
  logic                    load_c;

  // Output-register occupancy state
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fill on load, drain on a pop that has nothing to refill with
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (load_c) state_d = S_VALID;
      S_VALID: if (pop_c && mem_empty_c) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // Handshake controls derived from the current state and storage occupancy
  always_comb begin
    mem_empty_c = 1'b0;
    pop_c       = 1'b0;
    load_c      = 1'b0;
    mem_empty_c = (rd_ptr_q == write_addr_i);
    pop_c       = (state_q == S_VALID) && fifo_read_ready_h_i;
    load_c      = !mem_empty_c && ((state_q == S_EMPTY) || pop_c);
  end

  // Read pointer and output data register advance only on load
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rd_ptr_q <= '0;
      data_q   <= '0;
    end else if (load_c) begin
      rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      data_q   <= read_data_i;
    end
  end

  assign read_addr_o         = rd_ptr_q;
  assign fifo_read_data_o    = data_q;
  assign fifo_read_valid_h_o = (state_q == S_VALID);
  assign fifo_empty_h_o      = (state_q != S_VALID);

`ifdef SYNC_FIFO_OUT_LEVEL_EN
  logic [PTR_W-1:0] mem_count_c;

  // Entries in storage (wrap-bit pointer difference) plus the output register
  always_comb begin
    mem_count_c  = write_addr_i - rd_ptr_q;
    fifo_level_o = mem_count_c + PTR_W'(fifo_read_valid_h_o);
  end
`else
  assign fifo_level_o = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_out.sv
// Self-checking bench for sync_fifo_out with a behavioural write/storage stage.
module tb_sync_fifo_out;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  write_addr;
  logic [15:0] read_data;
  logic [4:0]  read_addr;
  logic        valid;
  logic        ready = 1'b0;
  logic [15:0] data;
  logic        empty;
  logic [4:0]  level;

  // write stage model
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic [15:0] mem [16];
  logic [4:0]  wptr;
  logic        full;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign full       = ((wptr ^ read_addr) == 5'h10);
  assign write_addr = wptr;
  assign read_data  = mem[read_addr[3:0]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
    end else if (wr_en && !full) begin
      mem[wptr[3:0]] <= wr_data;
      wptr <= wptr + 5'd1;
    end
  end

  sync_fifo_out #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk_i               (clk),
    .resetn_i            (rst_n),
    .write_addr_i        (write_addr),
    .read_data_i         (read_data),
    .read_addr_o         (read_addr),
    .fifo_read_valid_h_o (valid),
    .fifo_read_ready_h_i (ready),
    .fifo_read_data_o    (data),
    .fifo_empty_h_o      (empty),
    .fifo_level_o        (level)
  );

  function automatic logic [4:0] lvl(input int n);
`ifdef SYNC_FIFO_OUT_LEVEL_EN
    return 5'(n);
`else
    return 5'(0 * n);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic ev, input logic [15:0] ed,
                         input logic [4:0] ea, input int el);
    chk({name, ".valid"}, 32'(valid), 32'(ev));
    chk({name, ".empty"}, 32'(empty), 32'(!ev));
    chk({name, ".data"},  32'(data),  32'(ed));
    chk({name, ".addr"},  32'(read_addr), 32'(ea));
    chk({name, ".level"}, 32'(level), 32'(lvl(el)));
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] d;
    logic        rdy;
    logic        ev;
    logic [15:0] ed;
    logic [4:0]  ea;
    int          el;
  } vec_t;

  vec_t vt[12];

  initial begin
    int exp_n;
    int nvalid;
    int sent;
    int rcv;
    int cyc;
    logic accepted;

    // {wr, wr_data, ready, exp valid, exp data, exp read_addr, exp level}
    vt[0]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 5'd0, 1};
    vt[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 5'd1, 1};
    vt[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 5'd1, 1};
    vt[3]  = '{1'b1, 16'hAAAA, 1'b0, 1'b1, 16'h1234, 5'd1, 2};
    vt[4]  = '{1'b1, 16'h5555, 1'b1, 1'b1, 16'hAAAA, 5'd2, 2};
    vt[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h5555, 5'd3, 1};
    vt[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h5555, 5'd3, 0};
    vt[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h5555, 5'd3, 0};
    vt[8]  = '{1'b1, 16'h0F0F, 1'b1, 1'b0, 16'h5555, 5'd3, 1};
    vt[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0F0F, 5'd4, 1};
    vt[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0F0F, 5'd4, 1};
    vt[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0F0F, 5'd4, 0};

    // reset values
    do_reset();
    chk_out("reset", 1'b0, 16'h0000, 5'd0, 0);

    // directed vector table
    for (int i = 0; i < 12; i++) begin
      wr_en   = vt[i].wr;
      wr_data = vt[i].d;
      ready   = vt[i].rdy;
      step();
      chk_out($sformatf("vec%0d", i), vt[i].ev, vt[i].ed, vt[i].ea, vt[i].el);
    end
    wr_en = 1'b0;

    // stalled entry held for 10 cycles
    do_reset();
    wr_en = 1'b1; wr_data = 16'h1234;
    step();
    wr_en = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out($sformatf("stall%0d", i), 1'b1, 16'h1234, 5'd1, 1);
    end

    // 16 back-to-back entries with ready high: one per cycle, in order, wrap bit set
    do_reset();
    ready  = 1'b1;
    exp_n  = 1;
    nvalid = 0;
    for (int c = 0; c < 20; c++) begin
      wr_en   = (c < 16);
      wr_data = 16'(c + 1);
      step();
      chk($sformatf("b2b_valid%0d", c), 32'(valid), 32'((c >= 1) && (c <= 16)));
      if (valid) begin
        chk("b2b_data", 32'(data), 32'(exp_n));
        exp_n++;
        nvalid++;
      end
    end
    wr_en = 1'b0;
    chk("b2b_count", 32'(nvalid), 32'd16);
    chk("b2b_addr", 32'(read_addr), 32'h10);
    chk("b2b_empty", 32'(empty), 32'd1);

    // fill storage plus output register while stalled, then drain
    do_reset();
    for (int i = 0; i < 17; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'(16'h0200 + 16'(i + 1));
      step();
    end
    wr_en = 1'b0;
    chk("fill_full", 32'(full), 32'd1);
    chk_out("fill_state", 1'b1, 16'h0201, 5'd1, 17);
    wr_en = 1'b1; wr_data = 16'hDEAD;
    step();
    wr_en = 1'b0;
    chk("fill_reject_wptr", 32'(wptr), 32'd17);
    chk("fill_reject_level", 32'(level), 32'(lvl(17)));
    ready = 1'b1;
    exp_n = 2;
    for (int c = 0; c < 20; c++) begin
      step();
      if (c == 0) chk("fill_full_drop", 32'(full), 32'd0);
      if (valid) begin
        chk("fill_data", 32'(data), 32'(16'h0200 + 16'(exp_n)));
        exp_n++;
      end
    end
    chk("fill_count", 32'(exp_n), 32'd18);
    chk("fill_empty", 32'(empty), 32'd1);
    chk("fill_level0", 32'(level), 32'd0);

    // random ready and writes across two pointer wraps, scoreboard by sequence number
    do_reset();
    sent = 0;
    rcv  = 0;
    cyc  = 0;
    while (rcv < 40 && cyc < 2000) begin
      ready    = 1'($urandom_range(0, 1));
      wr_en    = (sent < 40) && ($urandom_range(0, 3) != 0);
      wr_data  = 16'(16'h0300 + 16'(sent));
      accepted = wr_en && !full;
      if (valid && ready) begin
        chk("rand_data", 32'(data), 32'(16'h0300 + 16'(rcv)));
        rcv++;
      end
      if (accepted) sent++;
      step();
      cyc++;
    end
    wr_en = 1'b0;
    ready = 1'b1;
    chk("rand_count", 32'(rcv), 32'd40);
    repeat (2) step();
    chk("rand_drained", 32'(valid), 32'd0);
    chk("rand_addr", 32'(read_addr), 32'd8);

    // asynchronous reset mid-transfer with 5 entries in storage
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'(16'h0400 + 16'(i));
      step();
    end
    wr_en = 1'b0;
    step();
    chk_out("pre_rst", 1'b1, 16'h0400, 5'd1, 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 16'h0000, 5'd0, 0);
    step();
    rst_n = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("post_rst%0d", i), 1'b0, 16'h0000, 5'd0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
